decode_format_arbiter: RTL and testbench

DECODE_FORMAT_ARBITER -- requirements
Module: decode_format_arbiter

---
 rtl/decode_format_arbiter_if.sv | 24 ++
 rtl/decode_format_arbiter.sv | 64 ++++++
 tb/tb_decode_format_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/decode_format_arbiter_if.sv
// decode_format_arbiter_if: requester, downstream and status signals of the decode format arbiter
interface decode_format_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int PAYLOAD_W = 160,
   parameter int DEPTH = 4
);
   logic flush_i;
   logic [NUM_REQ-1:0] reqValid_i;
   logic [NUM_REQ*PAYLOAD_W-1:0] reqPayload_i;
   logic [NUM_REQ-1:0] grant_o;
   logic [NUM_REQ-1:0] stall_o;
   logic enable_o;
   logic [PAYLOAD_W-1:0] payload_o;
   logic stall_i;
   logic [$clog2(DEPTH):0] count_o;
   modport master (
      output flush_i, reqValid_i, reqPayload_i, stall_i,
      input grant_o, stall_o, enable_o, payload_o, count_o
   );
   modport slave (
      input flush_i, reqValid_i, reqPayload_i, stall_i,
      output grant_o, stall_o, enable_o, payload_o, count_o
   );
endinterface

// File: rtl/decode_format_arbiter.sv
// decode_format_arbiter: round-robin arbiter from format decoders into an in-order output buffer
module decode_format_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PAYLOAD_W = 160,
   parameter int DEPTH = 4
) (
   input logic clock_i,
   input logic reset_i,
   decode_format_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(NUM_REQ);
   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [PAYLOAD_W-1:0] pl [NUM_REQ];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [IW-1:0] last_grant, gidx;
   logic full, pop, push, grant_ok;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_pl
      assign pl[i] = bus.reqPayload_i[(NUM_REQ-1-i)*PAYLOAD_W +: PAYLOAD_W];
   end
   assign full = bus.count_o == (AW+1)'(DEPTH);
   assign bus.enable_o = bus.count_o != '0;
   assign pop = bus.enable_o && !bus.stall_i && !bus.flush_i && !reset_i;
   assign grant_ok = (!full || pop) && !bus.flush_i && !reset_i;
   assign push = |bus.grant_o;
   assign bus.stall_o = bus.reqValid_i & ~bus.grant_o;
   // Scan farthest-first so the nearest valid requester after last_grant wins.
   always_comb begin
      bus.grant_o = '0;
      gidx = last_grant;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (grant_ok && bus.reqValid_i[IW'((int'(last_grant) + k) % NUM_REQ)]) begin
            gidx = IW'((int'(last_grant) + k) % NUM_REQ);
            bus.grant_o = NUM_REQ'(1) << gidx;
         end
      end
   end
   always_ff @(posedge clock_i) begin
      if (push) mem[wr_ptr] <= pl[gidx];
   end
   // payload_o is a register tracking the head so it holds its last value once empty.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         bus.count_o <= '0;
         bus.payload_o <= '0;
         last_grant <= IW'(NUM_REQ-1);
      end else if (bus.flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         bus.count_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (push) last_grant <= gidx;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         bus.count_o <= bus.count_o + (AW+1)'(push) - (AW+1)'(pop);
         if (push && (bus.count_o == '0 || (bus.count_o == (AW+1)'(1) && pop)))
            bus.payload_o <= pl[gidx];
         else if (pop && bus.count_o > (AW+1)'(1))
            bus.payload_o <= mem[rd_ptr + 1'b1];
      end
   end
endmodule

// File: tb/tb_decode_format_arbiter.sv
// tb_decode_format_arbiter: directed scenario checks of the decode format arbiter
module tb_decode_format_arbiter;
   logic clk = 0;
   logic rst = 1;
   int tests = 0;
   int fails = 0;
   logic [31:0] tag [4];
   decode_format_arbiter_if bus ();
   decode_format_arbiter dut (.clock_i(clk), .reset_i(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [159:0] pv(input logic [31:0] t);
      pv = {t, {3{32'hA5A5_5A5A}}, t};
   endfunction

   task automatic setpay(input int i, input logic [31:0] t);
      tag[i] = t;
      bus.reqPayload_i = {pv(tag[0]), pv(tag[1]), pv(tag[2]), pv(tag[3])};
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.reqValid_i = 4'b1111;
      #1;
      tests++; if (bus.grant_o !== 4'b0000) begin fails++; $display("FAIL rst_grant got=%b exp=0000", bus.grant_o); end
      tests++; if (bus.stall_o !== 4'b1111) begin fails++; $display("FAIL rst_stall got=%b exp=1111", bus.stall_o); end
      step; step;
      rst = 0;
      bus.reqValid_i = 4'b0000;
      #1;
      tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
      tests++; if (bus.enable_o !== 1'b0) begin fails++; $display("FAIL rst_enable got=%b exp=0", bus.enable_o); end
      tests++; if (bus.payload_o !== 160'd0) begin fails++; $display("FAIL rst_payload got=%h exp=0", bus.payload_o); end
   endtask

   task automatic test_round_robin;
      for (int i = 0; i < 4; i++) setpay(i, 32'h10 + i);
      bus.stall_i = 0;
      bus.reqValid_i = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         tests++; if (bus.grant_o !== (4'b0001 << k)) begin fails++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.grant_o, 4'b0001 << k); end
         if (k > 0) begin
            tests++; if (bus.payload_o !== pv(32'h10 + k - 1)) begin fails++; $display("FAIL rr_payload%0d got=%h exp=%h", k, bus.payload_o, pv(32'h10 + k - 1)); end
         end
         step;
      end
      bus.reqValid_i = 4'b0000;
      #1;
      tests++; if (bus.payload_o !== pv(32'h13) || bus.count_o !== 3'd1) begin fails++; $display("FAIL rr_last got=%h/%0d exp=%h/1", bus.payload_o, bus.count_o, pv(32'h13)); end
      step;
      tests++; if (bus.enable_o !== 1'b0 || bus.payload_o !== pv(32'h13)) begin fails++; $display("FAIL rr_empty_hold got=%b/%h exp=0/%h", bus.enable_o, bus.payload_o, pv(32'h13)); end
   endtask

   task automatic test_full;
      logic [31:0] exp_tags [4];
      exp_tags = '{32'h31, 32'h32, 32'h33, 32'h30};
      for (int i = 0; i < 4; i++) setpay(i, 32'h30 + i);
      bus.stall_i = 1;
      bus.reqValid_i = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         tests++; if (bus.grant_o !== (4'b0001 << k)) begin fails++; $display("FAIL full_grant%0d got=%b exp=%b", k, bus.grant_o, 4'b0001 << k); end
         step;
      end
      tests++; if (bus.count_o !== 3'd4) begin fails++; $display("FAIL full_count got=%0d exp=4", bus.count_o); end
      tests++; if (bus.grant_o !== 4'b0000 || bus.stall_o !== 4'b1111) begin fails++; $display("FAIL full_block got=%b/%b exp=0000/1111", bus.grant_o, bus.stall_o); end
      tests++; if (bus.payload_o !== pv(32'h30)) begin fails++; $display("FAIL full_head got=%h exp=%h", bus.payload_o, pv(32'h30)); end
      bus.stall_i = 0;
      #1;
      tests++; if (bus.grant_o !== 4'b0001) begin fails++; $display("FAIL full_pushpop_grant got=%b exp=0001", bus.grant_o); end
      step;
      bus.reqValid_i = 4'b0000;
      tests++; if (bus.count_o !== 3'd4) begin fails++; $display("FAIL full_pushpop_count got=%0d exp=4", bus.count_o); end
      for (int k = 0; k < 4; k++) begin
         #1;
         tests++; if (bus.enable_o !== 1'b1 || bus.payload_o !== pv(exp_tags[k])) begin fails++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", k, bus.enable_o, bus.payload_o, pv(exp_tags[k])); end
         step;
      end
      tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL full_drained got=%0d exp=0", bus.count_o); end
   endtask

   task automatic test_single;
      setpay(0, 32'hDEAD_0000);
      setpay(1, 32'hDEAD_0001);
      setpay(3, 32'hDEAD_0003);
      bus.stall_i = 0;
      bus.reqValid_i = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         setpay(2, 32'h20 + k);
         #1;
         tests++; if (bus.grant_o !== 4'b0100) begin fails++; $display("FAIL single_grant%0d got=%b exp=0100", k, bus.grant_o); end
         if (k > 0) begin
            tests++; if (bus.enable_o !== 1'b1 || bus.payload_o !== pv(32'h20 + k - 1)) begin fails++; $display("FAIL single_payload%0d got=%b/%h exp=1/%h", k, bus.enable_o, bus.payload_o, pv(32'h20 + k - 1)); end
         end
         step;
      end
      bus.reqValid_i = 4'b0000;
      #1;
      tests++; if (bus.enable_o !== 1'b1 || bus.payload_o !== pv(32'h22)) begin fails++; $display("FAIL single_last got=%b/%h exp=1/%h", bus.enable_o, bus.payload_o, pv(32'h22)); end
      step;
      tests++; if (bus.enable_o !== 1'b0) begin fails++; $display("FAIL single_empty got=%b exp=0", bus.enable_o); end
   endtask

   task automatic test_flush;
      for (int i = 0; i < 4; i++) setpay(i, 32'h40 + i);
      bus.stall_i = 1;
      bus.reqValid_i = 4'b1111;
      step; step; step;
      tests++; if (bus.count_o !== 3'd3) begin fails++; $display("FAIL flush_pre_count got=%0d exp=3", bus.count_o); end
      bus.flush_i = 1;
      bus.reqValid_i = 4'b0001;
      #1;
      tests++; if (bus.grant_o !== 4'b0000 || bus.stall_o !== 4'b0001) begin fails++; $display("FAIL flush_grant got=%b/%b exp=0000/0001", bus.grant_o, bus.stall_o); end
      step;
      bus.flush_i = 0;
      bus.reqValid_i = 4'b0000;
      #1;
      tests++; if (bus.count_o !== 3'd0 || bus.enable_o !== 1'b0) begin fails++; $display("FAIL flush_empty got=%0d/%b exp=0/0", bus.count_o, bus.enable_o); end
      tests++; if (bus.payload_o !== pv(32'h43)) begin fails++; $display("FAIL flush_hold got=%h exp=%h", bus.payload_o, pv(32'h43)); end
      bus.stall_i = 0;
      bus.reqValid_i = 4'b1111;
      #1;
      tests++; if (bus.grant_o !== 4'b0100) begin fails++; $display("FAIL flush_lastgrant got=%b exp=0100", bus.grant_o); end
      step;
      bus.reqValid_i = 4'b0000;
      step;
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 4; i++) setpay(i, 32'h50 + i);
      bus.stall_i = 1;
      bus.reqValid_i = 4'b1111;
      step; step;
      tests++; if (bus.count_o !== 3'd2) begin fails++; $display("FAIL rstmid_pre_count got=%0d exp=2", bus.count_o); end
      rst = 1;
      #1;
      tests++; if (bus.grant_o !== 4'b0000 || bus.stall_o !== 4'b1111) begin fails++; $display("FAIL rstmid_grant got=%b/%b exp=0000/1111", bus.grant_o, bus.stall_o); end
      step;
      rst = 0;
      #1;
      tests++; if (bus.count_o !== 3'd0 || bus.enable_o !== 1'b0 || bus.payload_o !== 160'd0) begin fails++; $display("FAIL rstmid_state got=%0d/%b/%h exp=0/0/0", bus.count_o, bus.enable_o, bus.payload_o); end
      tests++; if (bus.grant_o !== 4'b0001) begin fails++; $display("FAIL rstmid_next_grant got=%b exp=0001", bus.grant_o); end
      step;
      bus.reqValid_i = 4'b0000;
      bus.stall_i = 0;
      #1;
      tests++; if (bus.payload_o !== pv(32'h50)) begin fails++; $display("FAIL rstmid_payload got=%h exp=%h", bus.payload_o, pv(32'h50)); end
      step; step;
      tests++; if (bus.enable_o !== 1'b0 || bus.count_o !== 3'd0) begin fails++; $display("FAIL rstmid_no_stale got=%b/%0d exp=0/0", bus.enable_o, bus.count_o); end
   endtask

   task automatic test_stability;
      setpay(1, 32'h61);
      bus.stall_i = 1;
      bus.reqValid_i = 4'b0010;
      #1;
      tests++; if (bus.grant_o !== 4'b0010) begin fails++; $display("FAIL stab_grant got=%b exp=0010", bus.grant_o); end
      step;
      bus.reqValid_i = 4'b0000;
      setpay(1, 32'h99);
      for (int k = 0; k < 5; k++) begin
         tests++; if (bus.enable_o !== 1'b1 || bus.payload_o !== pv(32'h61)) begin fails++; $display("FAIL stab_hold%0d got=%b/%h exp=1/%h", k, bus.enable_o, bus.payload_o, pv(32'h61)); end
         step;
      end
      bus.stall_i = 0;
      step;
      tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL stab_drain got=%0d exp=0", bus.count_o); end
   endtask

   initial begin
      bus.flush_i = 0;
      bus.stall_i = 0;
      bus.reqValid_i = '0;
      for (int i = 0; i < 4; i++) setpay(i, 32'h0);
      step;
      test_reset;
      test_round_robin;
      test_full;
      test_single;
      test_flush;
      test_reset_mid;
      test_stability;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
